// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the matrix keypad scanner.
//   clog2()          constant width helper (returns 0 for value <= 1)
//   frame_class_e    classification of one full scan frame
//   state_e          debounce FSM states
package keypad_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small synchronous FIFO for key press events.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (empties the queue)
//   push_i  : write data_i this cycle
//   data_i  : event code to enqueue
//   pop_i   : consumer takes the head entry (ignored when empty)
//   data_o  : head entry, 0 when empty
//   empty_o : queue empty
//   full_o  : queue full
//   drop_o  : one-cycle pulse, registered, when a push was discarded
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         drop_o
);

  localparam int AW = clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         drop_q, drop_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full queue
  // still succeeds when the head is being consumed.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = push_i && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign drop_o = drop_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix keypad scanner with frame debounce.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   keypadCol : column sense lines, active low
//   keypadRow : row drive lines, one-cold
//   key_code  : code at event queue head (row*COLS+col)
//   key_valid : event queue not empty
//   key_ready : consumer accepts key_code when key_valid && key_ready
//   key_held  : a debounced key is currently held
//   overflow  : one-cycle pulse when a press event was dropped
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4,
  localparam int CW            = clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] keypadCol,
  output logic [ROWS-1:0] keypadRow,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow
);

  localparam int RW  = clog2(ROWS);
  localparam int CCW = clog2(COLS);
  localparam int SW  = clog2(SETTLE_CYCLES + 1);
  localparam int DW  = clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SCANS);

  // ---------------- scan timing ----------------
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          sample;
  logic          last_row;
  logic          frame_done;

  assign sample     = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign last_row   = (row_q == RW'(ROWS - 1));
  assign frame_done = sample && last_row;

  always_comb begin
    row_d    = row_q;
    settle_d = settle_q + SW'(1);
    if (sample) begin
      settle_d = '0;
      row_d    = last_row ? '0 : row_q + RW'(1);
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_drive
    assign keypadRow[gi] = (row_q != RW'(gi));
  end

  // ---------------- per-row column decode ----------------
  logic [1:0]     row_cnt;   // low column bits in this row, saturating at 2
  logic [CCW-1:0] row_col;
  logic [CW-1:0]  row_code;

  always_comb begin
    row_cnt = '0;
    row_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!keypadCol[c]) begin
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
        row_col = c[CCW-1:0];
      end
    end
  end

  assign row_code = CW'(row_q) * CW'(COLS) + CW'(row_col);

  // ---------------- frame accumulation ----------------
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [CW-1:0] acc_code_q, acc_code_d;
  logic [2:0]    sum_cnt;
  logic [1:0]    tot_cnt;
  logic [CW-1:0] frame_code;
  frame_class_e  frame_class;

  assign sum_cnt = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
  assign tot_cnt = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
  // With a total of one key, it came either from earlier rows or this one.
  assign frame_code = (acc_cnt_q != 2'd0) ? acc_code_q : row_code;

  always_comb begin
    unique case (tot_cnt)
      2'd0:    frame_class = FR_NONE;
      2'd1:    frame_class = FR_SINGLE;
      default: frame_class = FR_MULTI;
    endcase
  end

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      if (last_row) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = tot_cnt;
        acc_code_d = frame_code;
      end
    end
  end

  // ---------------- debounce FSM ----------------
  state_e        state_q, state_d;
  logic [CW-1:0] cand_q, cand_d;   // also serves as the held code while HELD
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rel_q, rel_d;
  logic          push_q, push_d;
  logic [CW-1:0] push_code_q, push_code_d;
  logic [DW-1:0] cnt_inc;
  logic [DW-1:0] rel_inc;
  logic [DW-1:0] idle_cnt;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    push_d      = 1'b0;
    push_code_d = push_code_q;
    cnt_inc     = (cnt_q == DMAX) ? cnt_q : cnt_q + DW'(1);
    rel_inc     = (rel_q == DMAX) ? rel_q : rel_q + DW'(1);
    idle_cnt    = (frame_code == cand_q) ? cnt_inc : DW'(1);
    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_class == FR_SINGLE) begin
            cand_d = frame_code;
            cnt_d  = idle_cnt;
            if (idle_cnt == DMAX) begin
              push_d      = 1'b1;
              push_code_d = frame_code;
              rel_d       = '0;
              state_d     = ST_HELD;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (frame_class == FR_NONE) begin
            if (rel_inc == DMAX) begin
              rel_d   = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            // Rollover to another key or ghosting keeps the current hold.
            rel_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q       <= '0;
      settle_q    <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
    end else begin
      row_q       <= row_d;
      settle_q    <= settle_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
    end
  end

  assign key_held = (state_q == ST_HELD);

  // ---------------- event queue ----------------
  logic fifo_empty;
  logic fifo_full;

  keypad_event_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_q),
    .data_i  (push_code_q),
    .pop_i   (key_ready),
    .data_o  (key_code),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (overflow)
  );

  assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int S     = 2;
  localparam int D     = 3;
  localparam int DEPTH = 4;
  localparam int F     = ROWS * S;
  localparam int NK    = ROWS * COLS;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [COLS-1:0] keypadCol;
  logic [ROWS-1:0] keypadRow;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            key_held;
  logic            overflow;
  logic [NK-1:0]   keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ovf_seen = 0;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    keypadCol = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!keypadRow[r] && keys[r*COLS+c]) keypadCol[c] = 1'b0;
  end

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(S),
    .DEBOUNCE_SCANS(D), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ---------------- reference model + scoreboard ----------------
  int  m_held, m_cand, m_cnt, m_rel;
  int  exp_q[$];
  bit  p1_v, p2_v;
  int  p1_c, p2_c;
  bit  exp_ovf;

  task automatic model_frame();
    int n, code;
    n = $countones(keys);
    code = 0;
    for (int i = 0; i < NK; i++) if (keys[i]) code = i;
    if (m_held == 0) begin
      if (n == 1) begin
        if (code == m_cand) m_cnt = (m_cnt < D) ? m_cnt + 1 : m_cnt;
        else begin m_cand = code; m_cnt = 1; end
        if (m_cnt == D) begin
          m_held = 1; m_rel = 0;
          p1_v = 1'b1; p1_c = code;
        end
      end else m_cnt = 0;
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == D) begin m_held = 0; m_cnt = 0; m_rel = 0; end
      end else m_rel = 0;
    end
  endtask

  always @(negedge clk) begin
    logic [ROWS-1:0] exp_row;
    if (!rst) begin
      m_held = 0; m_cand = 0; m_cnt = 0; m_rel = 0;
      p1_v = 1'b0; p2_v = 1'b0; exp_ovf = 1'b0;
      exp_q.delete();
    end else begin
      exp_ovf = 1'b0;
      if (p2_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(p2_c);
        else exp_ovf = 1'b1;
      end
      p2_v = p1_v; p2_c = p1_c; p1_v = 1'b0;

      exp_row = '1;
      exp_row[(cyc / S) % ROWS] = 1'b0;
      chk("row", int'(keypadRow), int'(exp_row));
      chk("valid", int'(key_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("head_code", int'(key_code), exp_q[0]);
      chk("held", int'(key_held), m_held);
      chk("overflow", int'(overflow), int'(exp_ovf));
      if (overflow) ovf_seen++;

      if (key_valid && key_ready && exp_q.size() != 0) begin
        $display("EVENT t=%0t code=%0d expected=%0d", $time, key_code, exp_q[0]);
        void'(exp_q.pop_front());
      end

      if (cyc % F == F - 1) model_frame();
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_frame();
    do begin
      @(posedge clk); #1;
    end while (cyc % F != 0);
  endtask

  task automatic frames(input int n);
    repeat (n) next_frame();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_row"},   int'(keypadRow), 4'b1110);
    chk({tag, "_valid"}, int'(key_valid), 0);
    chk({tag, "_code"},  int'(key_code),  0);
    chk({tag, "_held"},  int'(key_held),  0);
    chk({tag, "_ovf"},   int'(overflow),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, mode, nfr, base;
    repeat (3) @(posedge clk);
    #1 reset_checks("reset");
    #2 rst = 1'b1;

    // 1: idle scan
    frames(1);
    // 2: single key 6, pop once, release
    keys = NK'(1) << 6;
    frames(4);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    next_frame();
    keys = '0;
    frames(4);
    // 3: key 6 only in alternate frames
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? (NK'(1) << 6) : '0;
      frames(1);
    end
    keys = '0;
    frames(2);
    // 4: ghost frame, then the survivor key 11
    keys = (NK'(1) << 0) | (NK'(1) << 11);
    frames(4);
    keys = NK'(1) << 11;
    frames(4);
    keys = '0;
    frames(4);
    // 5: overflow on the fifth event, then drain
    key_ready = 1'b0;
    base = ovf_seen;
    for (int k = 1; k <= 5; k++) begin
      keys = NK'(1) << k;
      frames(4);
      keys = '0;
      frames(4);
    end
    chk("ovf_pulses", ovf_seen - base, 1);
    key_ready = 1'b1;
    frames(1);
    chk("drained", int'(key_valid), 0);
    // 6: reset while an event is queued and key held, key stays down
    key_ready = 1'b0;
    keys = NK'(1) << 9;
    frames(4);
    #2 rst = 1'b0;
    #1 reset_checks("midreset");
    @(posedge clk); #3 rst = 1'b1;
    frames(5);
    key_ready = 1'b1;
    frames(1);
    keys = '0;
    frames(4);

    // random phase
    repeat (40) begin
      mode = $urandom_range(0, 9);
      a = $urandom_range(0, NK - 1);
      b = (a + 1 + $urandom_range(0, NK - 2)) % NK;
      if (mode < 4)      keys = '0;
      else if (mode < 8) keys = NK'(1) << a;
      else               keys = (NK'(1) << a) | (NK'(1) << b);
      nfr = $urandom_range(1, 5);
      repeat (nfr * F) begin
        key_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end

    keys = '0;
    key_ready = 1'b1;
    frames(6);
    chk("final_queue", exp_q.size(), 0);
    chk("final_valid", int'(key_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 scan/pattern-select logic.
- Drives one-cold rows with per-row settle time and debounces over whole scan frames.
- Rejects multi-key (ghost) frames and emits one press event per debounced key into a small FIFO with a valid/ready interface.
- Sits between the keypad pins and the pattern/draw control logic, which maps key codes to actions.

Parameters:
- ROWS, 4, number of row drive lines (>=2)
- COLS, 4, number of column sense lines (>=2)
- SETTLE_CYCLES, 2, clocks each row is driven before its columns are sampled (>=1)
- DEBOUNCE_SCANS, 3, consecutive identical frames needed to accept a press or a release (>=1)
- FIFO_DEPTH, 4, press-event queue depth (power of 2, >=2)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-low reset
- keypadCol, in, COLS, column sense lines, active low
- keypadRow, out, ROWS, row drive lines, one-cold (the driven row is 0)
- key_code, out, CW=clog2(ROWS*COLS), code at FIFO head = row*COLS+col
- key_valid, out, 1, FIFO not empty
- key_ready, in, 1, consumer accepts key_code when key_valid && key_ready
- key_held, out, 1, a debounced key is currently held
- overflow, out, 1, one-cycle pulse when an event is dropped

Behaviour:
- Reset (async, rst=0): keypadRow = all ones with bit0=0; key_valid=0, key_code=0, key_held=0, overflow=0. FIFO emptied; all counters, candidate and held code cleared. Reset mid-debounce discards partial progress.
- Scan timing:
  - Row r is driven for SETTLE_CYCLES clocks; keypadCol is sampled on the last of them.
  - On the next edge the one-cold pattern advances to r+1; after ROWS-1 it wraps to 0.
  - One frame = ROWS*SETTLE_CYCLES clocks.
- Frame summary: the number of low column bits is accumulated over all rows. Frame is classed as NONE (0 keys), SINGLE(code) (exactly 1), or MULTI (>=2). It is evaluated in the cycle the last row is sampled.
- Debounce FSM, states IDLE and HELD:
  - IDLE, SINGLE(c):
    - c equals the candidate -> cnt+1.
    - else candidate=c, cnt=1.
    - When cnt reaches DEBOUNCE_SCANS: push c, held_code=c, key_held=1, go HELD.
  - IDLE, NONE or MULTI -> cnt=0.
  - HELD, NONE -> rel_cnt+1. At DEBOUNCE_SCANS: key_held=0, cnt=0, go IDLE.
  - HELD, any other frame -> rel_cnt=0. No repeat events; rollover to a second key is ignored until release.
- FIFO:
  - key_valid = not empty.
  - key_code = head entry, stable while key_valid && !key_ready.
  - Push becomes visible on key_valid the cycle after the push edge.
  - Push while full without a same-cycle pop -> event dropped, overflow=1 for one cycle.
  - Push and pop in the same cycle while full -> both succeed.
  - Pop when empty is ignored.
- Latency: a clean press present from a frame start gives key_valid DEBOUNCE_SCANS frames later, plus 1 clock.
- Width rules:
  - Code arithmetic is done in CW bits.
  - Frame key count saturates at 2.
  - cnt and rel_cnt are clog2(DEBOUNCE_SCANS+1) bits wide and saturate.

Decomposition:
- Shared package keypad_pkg:
  - clog2 function and CW derivation
  - frame-class encodings NONE/SINGLE/MULTI
  - FSM state encodings IDLE/HELD
- One natural sub-module: keypad_event_fifo (synchronous FIFO with push/pop/full/empty and a drop-on-full pulse).

Test Plan (ROWS=4, COLS=4, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3, FIFO_DEPTH=4):
1. Reset, then run 8 clocks with no keys -> keypadRow 1110,1110,1101,1101,1011,1011,0111,0111, then back to 1110. key_valid=0 throughout.
2. Hold row1/col2 (keypadCol=4'b1011 while keypadRow=1101) from a frame start -> after 3 frames+1 clock, key_valid=1, key_code=6, key_held=1. Pulse key_ready -> key_valid=0 and no repeat. Release 3 frames -> key_held=0.
3. Key 6 present only in alternate frames -> cnt never reaches 3, key_valid stays 0.
4. Press codes 0 and 11 together -> no event (MULTI). Release code 0 -> event code 11 after 3 frames.
5. key_ready=0, five press/release cycles of codes 1,2,3,4,5 -> overflow pulses once on the 5th push. Drain yields 1,2,3,4 in order.
6. Assert rst after 2 frames of a held key -> outputs at reset values immediately. After release of reset, key_valid is asserted only after 3 full new frames+1 clock.
